// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the tri-colour LED PWM driver.
//   PWM_MAX    last pwm_cnt value of a period (255 steps: 0..254)
//   state_e    IDLE/RUN controller state
//   GAMMA_LUT  round(255*(n/15)^2.2) for n = 0..15
//   duty_map   4-bit colour channel -> 8-bit duty
// Build option: define RGB_PWM_GAMMA_EN to map channels through GAMMA_LUT;
// otherwise the linear {c,c} map is used.
package rgb_pwm_pkg;

    localparam logic [7:0] PWM_MAX = 8'd254;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [7:0] GAMMA_LUT [16] = '{
        8'd0,   8'd1,   8'd3,   8'd7,   8'd14,  8'd23,  8'd34,  8'd48,
        8'd64,  8'd83,  8'd105, 8'd129, 8'd156, 8'd186, 8'd219, 8'd255
    };

    function automatic logic [7:0] duty_map(input logic [3:0] c);
        logic [7:0] lin;
        logic [7:0] gam;
        lin = {c, c};
        gam = GAMMA_LUT[c];
`ifdef RGB_PWM_GAMMA_EN
        return gam;
`else
        return lin;
`endif
    endfunction

endpackage

// File: rtl/rgb_led_pwm_if.sv
// Colour/enable input and LED output bundle of the tri-colour LED driver.
//   rgb_in        {R[3:0],G[3:0],B[3:0]} colour word
//   enable        high = run PWM, low = LEDs dark
//   led_r/g/b     active-high PWM outputs
//   period_start  1-cycle pulse when new shadow duties load
// master: the colour source; slave: the PWM driver.
interface rgb_led_pwm_if;
    logic [11:0] rgb_in;
    logic        enable;
    logic        led_r;
    logic        led_g;
    logic        led_b;
    logic        period_start;

    modport master (
        output rgb_in, enable,
        input  led_r, led_g, led_b, period_start
    );

    modport slave (
        input  rgb_in, enable,
        output led_r, led_g, led_b, period_start
    );
endinterface

// File: rtl/rgb_pwm_channel.sv
// One PWM colour channel: shadow duty register plus registered comparator.
//   clk, reset  system clock, synchronous active-high reset
//   load        capture duty_map(colour) into the shadow register
//   run         controller stays in RUN across this edge
//   pwm_cnt     shared 0..254 period counter
//   colour      4-bit channel value from the colour word
//   led         registered PWM output
module rgb_pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       run,
    input  logic [7:0] pwm_cnt,
    input  logic [3:0] colour,
    output logic       led
);

    logic [7:0] shadow_q;

    // Compare uses the pre-load shadow, so a new duty shows one clock after the load edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= 8'h00;
            led      <= 1'b0;
        end else begin
            if (load) begin
                shadow_q <= duty_map(colour);
            end
            led <= run && (pwm_cnt < shadow_q);
        end
    end

endmodule

// File: rtl/rgb_led_pwm.sv
// Tri-colour LED PWM driver: prescaler, 255-step period counter, IDLE/RUN
// controller and three shadowed PWM channels. Colours load only at period
// boundaries (or when enabled from IDLE), so outputs never glitch mid-period.
//   clk    system clock
//   reset  synchronous, active-high
//   bus    rgb_led_pwm_if slave: rgb_in, enable in; led_r/g/b, period_start out
// Parameter PRESCALE: clk cycles per PWM step (>= 1).
// Build option RGB_PWM_GAMMA_EN selects gamma-corrected duties (see rgb_pwm_pkg).
module rgb_led_pwm
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 392
) (
    input  logic               clk,
    input  logic               reset,
    rgb_led_pwm_if.slave       bus
);

    localparam int unsigned     PreW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

    state_e          state_q, state_d;
    logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]      pwm_cnt_q, pwm_cnt_d;
    logic            period_start_q, period_start_d;
    logic            load;
    logic            run;
    logic            tick;
    logic            led_r, led_g, led_b;

    assign tick = (state_q == RUN) && (pre_cnt_q == PreMax);
    // Leds are gated by the state after this edge so a disable darkens them immediately.
    assign run  = (state_q == RUN) && bus.enable;

    always_comb begin
        state_d        = state_q;
        pre_cnt_d      = pre_cnt_q;
        pwm_cnt_d      = pwm_cnt_q;
        period_start_d = 1'b0;
        load           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d        = RUN;
                    pre_cnt_d      = '0;
                    pwm_cnt_d      = 8'd0;
                    load           = 1'b1;
                    period_start_d = 1'b1;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    // Disable beats a coincident wrap: no reload, no pulse.
                    state_d   = IDLE;
                    pre_cnt_d = '0;
                    pwm_cnt_d = 8'd0;
                end else begin
                    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
                    if (tick) begin
                        if (pwm_cnt_q == PWM_MAX) begin
                            pwm_cnt_d      = 8'd0;
                            load           = 1'b1;
                            period_start_d = 1'b1;
                        end else begin
                            pwm_cnt_d = pwm_cnt_q + 8'd1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= 8'd0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
        end
    end

    rgb_pwm_channel u_red (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .run     (run),
        .pwm_cnt (pwm_cnt_q),
        .colour  (bus.rgb_in[11:8]),
        .led     (led_r)
    );

    rgb_pwm_channel u_grn (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .run     (run),
        .pwm_cnt (pwm_cnt_q),
        .colour  (bus.rgb_in[7:4]),
        .led     (led_g)
    );

    rgb_pwm_channel u_blu (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .run     (run),
        .pwm_cnt (pwm_cnt_q),
        .colour  (bus.rgb_in[3:0]),
        .led     (led_b)
    );

    assign bus.led_r        = led_r;
    assign bus.led_g        = led_g;
    assign bus.led_b        = led_b;
    assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Self-checking bench for rgb_led_pwm with PRESCALE=2 (510 clk per period).
// Define RGB_PWM_GAMMA_EN on both RTL and bench for the gamma build.
module tb_rgb_led_pwm;
    import rgb_pwm_pkg::*;

    localparam int Period = 510;
    localparam int Budget = 1200;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    rgb_led_pwm_if bus ();

    rgb_led_pwm #(
        .PRESCALE (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        int          exp_r;
        int          exp_g;
        int          exp_b;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until period_start is seen; returns cycles taken, or -1 on timeout.
    task automatic wait_ps(output int n);
        n = -1;
        for (int i = 1; i <= Budget; i++) begin
            step();
            if (bus.period_start) begin
                n = i;
                break;
            end
        end
        if (n < 0) check("period_start timeout", 0, 1);
    endtask

    initial begin
        int n, cr, cg, cb, cps, bad;
        tests = 0;
        fails = 0;

`ifdef RGB_PWM_GAMMA_EN
        vecs[0] = '{12'h080, 0, 128, 0};
        vecs[1] = '{12'hF00, 510, 0, 0};
        vecs[2] = '{12'h18F, 2, 128, 510};
        vecs[3] = '{12'h5A3, 46, 210, 14};
`else
        vecs[0] = '{12'h080, 0, 272, 0};
        vecs[1] = '{12'hF00, 510, 0, 0};
        vecs[2] = '{12'h18F, 34, 272, 510};
        vecs[3] = '{12'h5A3, 170, 340, 102};
`endif
        vecs[4] = '{12'h000, 0, 0, 0};
        vecs[5] = '{12'hFFF, 510, 510, 510};

        // Reset held with enable high: everything stays dark
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.rgb_in = 12'hFFF;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.led_r || bus.led_g || bus.led_b || bus.period_start) bad++;
        end
        check("reset outputs low", bad, 0);
        check("reset state IDLE", dut.state_q, IDLE);

        // Enable rise with red only
        bus.enable = 1'b0;
        bus.rgb_in = 12'hF00;
        reset = 1'b0;
        step();
        step();
        check("idle period_start", bus.period_start, 0);
        bus.enable = 1'b1;
        step();
        check("enable period_start", bus.period_start, 1);
        check("enable led_r first cycle", bus.led_r, 0);
        step();
        check("period_start one cycle", bus.period_start, 0);
        bad = 0;
        cg = 0;
        for (int i = 0; i < 600; i++) begin
            if (!bus.led_r) bad++;
            if (bus.led_g || bus.led_b) cg++;
            step();
        end
        check("led_r continuous", bad, 0);
        check("led_g/led_b dark", cg, 0);

        // Table: per-period high counts for each colour word
        foreach (vecs[v]) begin
            bus.rgb_in = vecs[v].rgb;
            wait_ps(n);
            cr = 0; cg = 0; cb = 0; cps = 0;
            for (int k = 1; k <= Period; k++) begin
                step();
                cr += int'(bus.led_r);
                cg += int'(bus.led_g);
                cb += int'(bus.led_b);
                cps += int'(bus.period_start);
            end
            check($sformatf("vec%0d led_r count", v), cr, vecs[v].exp_r);
            check($sformatf("vec%0d led_g count", v), cg, vecs[v].exp_g);
            check($sformatf("vec%0d led_b count", v), cb, vecs[v].exp_b);
            check($sformatf("vec%0d period_start count", v), cps, 1);
        end

        // Mid-period colour swap at pwm_cnt=100
        bus.rgb_in = 12'h00F;
        wait_ps(n);
        wait_ps(n);
        repeat (200) step();
        check("swap at pwm_cnt 100", dut.pwm_cnt_q, 100);
        bus.rgb_in = 12'h0F0;
        bad = 0;
        n = -1;
        for (int k = 201; k <= Budget; k++) begin
            step();
            if (bus.period_start) begin
                n = k;
                break;
            end
            if (!bus.led_b || bus.led_g) bad++;
        end
        check("period_start spacing", n, Period);
        check("old colour held to wrap", bad, 0);
        check("led_b on wrap cycle", bus.led_b, 1);
        check("led_g off wrap cycle", bus.led_g, 0);
        step();
        check("swap led_g on", bus.led_g, 1);
        check("swap led_b off", bus.led_b, 0);

        // Disable at pwm_cnt=50, then re-enable
        bus.rgb_in = 12'hFFF;
        wait_ps(n);
        repeat (100) step();
        check("pre-disable leds on", {bus.led_r, bus.led_g, bus.led_b}, 3'b111);
        bus.enable = 1'b0;
        step();
        check("disable leds off", {bus.led_r, bus.led_g, bus.led_b}, 3'b000);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.led_r || bus.led_g || bus.led_b || bus.period_start) bad++;
        end
        check("idle stays dark", bad, 0);
        bus.enable = 1'b1;
        step();
        check("re-enable period_start", bus.period_start, 1);
        check("re-enable pwm_cnt", dut.pwm_cnt_q, 0);
        step();
        check("re-enable leds on", {bus.led_r, bus.led_g, bus.led_b}, 3'b111);

        // Disable on the wrap tick: no pulse, shadow keeps FF
        wait_ps(n);
        bus.rgb_in = 12'h000;
        repeat (Period - 1) step();
        check("wrap tick pwm_cnt", dut.pwm_cnt_q, 254);
        bus.enable = 1'b0;
        step();
        check("wrap disable no period_start", bus.period_start, 0);
        check("wrap disable leds off", {bus.led_r, bus.led_g, bus.led_b}, 3'b000);
        check("wrap disable shadow held", dut.u_red.shadow_q, 8'hFF);
        check("wrap disable state IDLE", dut.state_q, IDLE);

        // Reset mid-RUN
        bus.rgb_in = 12'hFFF;
        bus.enable = 1'b1;
        repeat (22) step();
        check("pre-reset leds on", {bus.led_r, bus.led_g, bus.led_b}, 3'b111);
        reset = 1'b1;
        step();
        check("mid-run reset leds off", {bus.led_r, bus.led_g, bus.led_b, bus.period_start},
              4'b0000);
        check("mid-run reset state IDLE", dut.state_q, IDLE);
        reset = 1'b0;
        bus.enable = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
